// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV32M divider.
// Provides the operation encodings (equal to funct3[1:0]), the FSM state
// encodings and a helper that sizes the iteration counter.
package div_pkg;

    // Operation encodings, equal to funct3[1:0] of DIV/DIVU/REM/REMU
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // FSM states
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_CALC = 2'b01;
    localparam logic [1:0] S_FIN  = 2'b10;

    // Counter width able to hold 0 .. data_width-1
    function automatic int div_cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/div_magnitude.sv
// Conditional two's-complement negator.
// Ports:
//   in     - value to pass through or negate
//   neg_en - 1: out = -in (wraps at WIDTH bits), 0: out = in
//   out    - result
module div_magnitude #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg_en,
    output logic [WIDTH-1:0] out
);

    // Negate on request; the most-negative value wraps to itself
    always_comb begin
        out = in;
        if (neg_en) begin
            out = ~in + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            out = in;
        end
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle, DATA_WIDTH iterations, fixed latency.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - request pulse, accepted only in IDLE
//   op         - funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a, b       - dividend (rs1) and divisor (rs2)
//   busy       - high whenever the FSM is not in IDLE
//   done       - one-cycle pulse while out carries the new result
//   out        - quotient or remainder, held until the next accepted start
module iter_divider
    import div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int CNT_W = div_cnt_width(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZERO     = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]            state_r;
    logic [1:0]            op_r;
    logic                  a_neg_r;
    logic                  b_neg_r;
    logic [DATA_WIDTH-1:0] a_raw_r;
    logic [DATA_WIDTH-1:0] b_mag_r;
    logic                  div_zero_r;
    logic                  ovf_r;
    logic [DATA_WIDTH-1:0] quo_r;
    logic [DATA_WIDTH-1:0] rem_r;
    logic [CNT_W-1:0]      count_r;
    logic [DATA_WIDTH-1:0] out_r;
    logic                  busy_r;
    logic                  done_r;

    logic                  in_signed_s;
    logic [DATA_WIDTH-1:0] a_mag_s;
    logic [DATA_WIDTH-1:0] b_mag_s;
    logic [DATA_WIDTH:0]   trial_s;
    logic [DATA_WIDTH-1:0] quo_next_s;
    logic [DATA_WIDTH-1:0] rem_next_s;
    logic [DATA_WIDTH-1:0] fix_in_s;
    logic                  fix_neg_s;
    logic [DATA_WIDTH-1:0] fix_out_s;
    logic [DATA_WIDTH-1:0] result_s;

    // DIV and REM are the signed operations (op[0] == 0)
    assign in_signed_s = ~op[0];

    div_magnitude #(.WIDTH(DATA_WIDTH)) u_a_mag (
        .in     (a),
        .neg_en (in_signed_s & a[DATA_WIDTH-1]),
        .out    (a_mag_s)
    );

    div_magnitude #(.WIDTH(DATA_WIDTH)) u_b_mag (
        .in     (b),
        .neg_en (in_signed_s & b[DATA_WIDTH-1]),
        .out    (b_mag_s)
    );

    // Trial subtraction is one bit wider so its MSB is the borrow/sign
    assign trial_s = {rem_r, quo_r[DATA_WIDTH-1]} - {1'b0, b_mag_r};

    // Restoring step: keep the difference if non-negative, else the shifted value
    always_comb begin
        rem_next_s = rem_r;
        quo_next_s = quo_r;
        if (!trial_s[DATA_WIDTH]) begin
            rem_next_s = trial_s[DATA_WIDTH-1:0];
            quo_next_s = {quo_r[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = {rem_r[DATA_WIDTH-2:0], quo_r[DATA_WIDTH-1]};
            quo_next_s = {quo_r[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Pick quotient or remainder and decide whether its sign must be flipped
    always_comb begin
        fix_in_s  = quo_next_s;
        fix_neg_s = 1'b0;
        if (op_r[1]) begin
            fix_in_s  = rem_next_s;
            fix_neg_s = ~op_r[0] & a_neg_r;
        end else begin
            fix_in_s  = quo_next_s;
            fix_neg_s = ~op_r[0] & (a_neg_r ^ b_neg_r);
        end
    end

    div_magnitude #(.WIDTH(DATA_WIDTH)) u_res_fix (
        .in     (fix_in_s),
        .neg_en (fix_neg_s),
        .out    (fix_out_s)
    );

    // Final result with divide-by-zero and signed-overflow overrides
    always_comb begin
        result_s = fix_out_s;
        if (div_zero_r) begin
            result_s = op_r[1] ? a_raw_r : ALL_ONES;
        end else if (ovf_r) begin
            result_s = op_r[1] ? ZERO : MOST_NEG;
        end else begin
            result_s = fix_out_s;
        end
    end

    // Control FSM, operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            op_r       <= 2'b00;
            a_neg_r    <= 1'b0;
            b_neg_r    <= 1'b0;
            a_raw_r    <= ZERO;
            b_mag_r    <= ZERO;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
            quo_r      <= ZERO;
            rem_r      <= ZERO;
            count_r    <= {CNT_W{1'b0}};
            out_r      <= ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        op_r       <= op;
                        a_neg_r    <= a[DATA_WIDTH-1];
                        b_neg_r    <= b[DATA_WIDTH-1];
                        a_raw_r    <= a;
                        b_mag_r    <= b_mag_s;
                        div_zero_r <= (b == ZERO);
                        ovf_r      <= in_signed_s & (a == MOST_NEG) & (b == ALL_ONES);
                        quo_r      <= a_mag_s;
                        rem_r      <= ZERO;
                        count_r    <= {CNT_W{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= S_CALC;
                    end
                end
                S_CALC: begin
                    quo_r <= quo_next_s;
                    rem_r <= rem_next_s;
                    if (count_r == CNT_LAST) begin
                        out_r   <= result_s;
                        done_r  <= 1'b1;
                        state_r <= S_FIN;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                S_FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: scoreboard of expected results,
// popped and compared whenever the DUT pulses done.
module tb_iter_divider;
    import div_pkg::*;

    localparam int DW = 32;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          busy;
    logic          done;
    logic [DW-1:0] out;

    int        n_checks = 0;
    int        n_errs   = 0;
    sb_entry_t exp_q[$];

    iter_divider #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Independent reference using the simulator's signed/unsigned division
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            DIV_OP_DIV:  return sx / sy;
            DIV_OP_DIVU: return x / y;
            DIV_OP_REM:  return sx % sy;
            default:     return x % y;
        endcase
    endfunction

    // Scoreboard: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("stray_done", 32'(done), 32'd0);
            end else begin
                sb_entry_t e;
                e = exp_q.pop_front();
                chk(e.tag, out, e.exp);
            end
        end
    end

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e);
        int lat;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back('{tag, e});
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble inputs: the captured operands must be used
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(DW));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(DW + 1));
        @(posedge clk);
        #1;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        bit          seen;

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic and signed cases
        run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("div_m7_2",   DIV_OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   DIV_OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div_7_m2",   DIV_OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        // Divide by zero
        run_op("div_by0",    DIV_OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_by0",   DIV_OP_REMU, 32'h8000_0001, 32'd0, 32'h8000_0001);
        run_op("rem_by0",    DIV_OP_REM,  32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0);
        // Signed overflow
        run_op("div_ovf",    DIV_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    DIV_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_max",   DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op($sformatf("rand%0d", i), ro, rx, ry, model(ro, rx, ry));
        end

        // Starts during CALC and FIN are ignored
        @(negedge clk);
        op = DIV_OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        exp_q.push_back('{"ign_divu_100_7", 32'd14});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a = 32'd9; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        chk("ign_done_seen", 32'(seen), 32'd1);
        a = 32'd9; b = 32'd3; start = 1'b1;   // pulse during FIN
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("ign_idle_busy", 32'(busy), 32'd0);
        chk("ign_out_hold", out, 32'd14);
        chk("ign_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        op = DIV_OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_out", out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3);

        repeat (3) @(posedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
